// File: rtl/operand_forward_stage_pkg.sv
// Shared pipeline definitions for the operand forwarding stage.
// Holds the PC register index, forward-select encoding and width defaults.
package operand_forward_stage_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CTRL_WIDTH = 16;
  localparam int NUM_SRC        = 3;

  // R15 reads back the program counter and is never a forwarding target.
  localparam int REG_PC = 15;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_forward_stage_forward_mux.sv
// Per-operand forwarding mux: picks the youngest in-flight producer of the
// source register, falling back to register-file data.
module forward_mux
  import operand_forward_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] rx,
  input  logic [DATA_WIDTH-1:0] px,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic                  ex_le,
  input  logic                  ex_load,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic                  mem_le,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic                  wb_le,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic [DATA_WIDTH-1:0] operand
);

  fwd_sel_e sel;

  // A load still in EX has no data yet; the hazard logic stalls instead.
  always_comb begin
    sel = FWD_RF;
    if (rx != ADDR_WIDTH'(REG_PC)) begin
      if (ex_le && !ex_load && ex_rd == rx) begin
        sel = FWD_EX;
      end else if (mem_le && mem_rd == rx) begin
        sel = FWD_MEM;
      end else if (wb_le && wb_rd == rx) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    operand = px;
    case (sel)
      FWD_EX:  operand = ex_result;
      FWD_MEM: operand = mem_result;
      FWD_WB:  operand = wb_result;
      default: operand = px;
    endcase
  end

endmodule

// File: rtl/operand_forward_stage.sv
// Decode-to-execute boundary: forwards operands, detects load-use hazards,
// and holds the ID/EX register plus a saturating stall-cycle counter.
module operand_forward_stage
  import operand_forward_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [ADDR_WIDTH-1:0] rb,
  input  logic [ADDR_WIDTH-1:0] rc,
  input  logic                  use_a,
  input  logic                  use_b,
  input  logic                  use_c,
  input  logic [DATA_WIDTH-1:0] pa,
  input  logic [DATA_WIDTH-1:0] pb,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  id_valid,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic                  ex_le,
  input  logic                  mem_le,
  input  logic                  wb_le,
  input  logic                  ex_load,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] op_c,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic                  ex_valid,
  output logic [31:0]           stall_count
);

  logic [ADDR_WIDTH-1:0] src_addr [NUM_SRC];
  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [DATA_WIDTH-1:0] resolved [NUM_SRC];
  logic [NUM_SRC-1:0]    src_use;
  logic [NUM_SRC-1:0]    src_hazard;

  logic [DATA_WIDTH-1:0] op_reg  [NUM_SRC];
  logic [DATA_WIDTH-1:0] op_next [NUM_SRC];
  logic [CTRL_WIDTH-1:0] ex_ctrl_reg, ex_ctrl_next;
  logic                  ex_valid_reg, ex_valid_next;
  logic [31:0]           stall_count_reg, stall_count_next;

  assign src_addr[0] = ra;
  assign src_addr[1] = rb;
  assign src_addr[2] = rc;
  assign src_data[0] = pa;
  assign src_data[1] = pb;
  assign src_data[2] = pc;
  assign src_use     = {use_c, use_b, use_a};

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      forward_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_forward_mux (
        .rx         (src_addr[gi]),
        .px         (src_data[gi]),
        .ex_rd      (ex_rd),
        .ex_le      (ex_le),
        .ex_load    (ex_load),
        .ex_result  (ex_result),
        .mem_rd     (mem_rd),
        .mem_le     (mem_le),
        .mem_result (mem_result),
        .wb_rd      (wb_rd),
        .wb_le      (wb_le),
        .wb_result  (wb_result),
        .operand    (resolved[gi])
      );

      // Forwarding ignores use_x; only the hazard check cares whether the source is read.
      assign src_hazard[gi] = src_use[gi] && (src_addr[gi] == ex_rd) &&
                              (src_addr[gi] != ADDR_WIDTH'(REG_PC));
    end
  endgenerate

  assign stall = id_valid && !flush && ex_le && ex_load && (|src_hazard);

  always_comb begin
    ex_valid_next = 1'b0;
    ex_ctrl_next  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      op_next[i] = '0;
    end
    if (!flush && !stall) begin
      ex_valid_next = id_valid;
      ex_ctrl_next  = id_ctrl;
      for (int i = 0; i < NUM_SRC; i++) begin
        op_next[i] = resolved[i];
      end
    end
  end

  always_comb begin
    stall_count_next = stall_count_reg;
    if (stall && stall_count_reg != 32'hFFFF_FFFF) begin
      stall_count_next = stall_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg    <= 1'b0;
      ex_ctrl_reg     <= '0;
      stall_count_reg <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        op_reg[i] <= '0;
      end
    end else begin
      ex_valid_reg    <= ex_valid_next;
      ex_ctrl_reg     <= ex_ctrl_next;
      stall_count_reg <= stall_count_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        op_reg[i] <= op_next[i];
      end
    end
  end

  assign op_a        = op_reg[0];
  assign op_b        = op_reg[1];
  assign op_c        = op_reg[2];
  assign ex_ctrl     = ex_ctrl_reg;
  assign ex_valid    = ex_valid_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_operand_forward_stage.sv
// Directed self-checking bench for operand_forward_stage: reset, forwarding
// priority, PC bypass, load-use stall, flush, and counter saturation.
module tb_operand_forward_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ra, rb, rc;
  logic        use_a, use_b, use_c;
  logic [31:0] pa, pb, pc;
  logic        id_valid;
  logic [15:0] id_ctrl;
  logic        flush;
  logic [3:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_le, mem_le, wb_le, ex_load;
  logic [31:0] ex_result, mem_result, wb_result;
  logic        stall;
  logic [31:0] op_a, op_b, op_c;
  logic [15:0] ex_ctrl;
  logic        ex_valid;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_forward_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ra(ra), .rb(rb), .rc(rc),
    .use_a(use_a), .use_b(use_b), .use_c(use_c),
    .pa(pa), .pb(pb), .pc(pc),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .flush(flush),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_le(ex_le), .mem_le(mem_le), .wb_le(wb_le), .ex_load(ex_load),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .stall(stall), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stages();
    ex_le = 0; mem_le = 0; wb_le = 0; ex_load = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0;
  endtask

  initial begin
    rst_n = 0;
    ra = 0; rb = 0; rc = 0; use_a = 0; use_b = 0; use_c = 0;
    pa = 0; pb = 0; pc = 0; id_valid = 0; id_ctrl = 0; flush = 0;
    ex_result = 0; mem_result = 0; wb_result = 0;
    clear_stages();
    step(); step();
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_stall_count", stall_count, 0);
    rst_n = 1;

    // No hazard
    ra = 3; pa = 20; use_a = 1; id_valid = 1; id_ctrl = 16'hA5A5;
    step();
    chk("nohaz_op_a", op_a, 20);
    chk("nohaz_ex_valid", ex_valid, 1);
    chk("nohaz_ex_ctrl", ex_ctrl, 16'hA5A5);

    // Forward priority
    ra = 5; ex_rd = 5; mem_rd = 5; wb_rd = 5;
    ex_le = 1; mem_le = 1; wb_le = 1; ex_load = 0;
    ex_result = 100; mem_result = 200; wb_result = 300;
    #1 chk("prio_no_stall", stall, 0);
    step();
    chk("prio_ex", op_a, 100);
    ex_le = 0;
    step();
    chk("prio_mem", op_a, 200);
    mem_le = 0; use_a = 0;
    step();
    chk("prio_wb_unused", op_a, 300);

    // PC bypass
    clear_stages(); ra = 3;
    rb = 15; pb = 32; ex_rd = 15; ex_le = 1; ex_result = 99; use_b = 1;
    step();
    chk("pc_op_b", op_b, 32);
    chk("pc_op_a_rf", op_a, 20);

    // Load-use
    clear_stages(); use_b = 0; rb = 0; pb = 0;
    ex_load = 1; ex_rd = 7; ex_le = 1; rc = 7; pc = 11; use_c = 1; id_ctrl = 16'h1234;
    #1 chk("lu_stall", stall, 1);
    step();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    chk("lu_bubble_op_c", op_c, 0);
    chk("lu_count", stall_count, 1);
    clear_stages(); mem_rd = 7; mem_le = 1; mem_result = 55;
    #1 chk("lu_next_no_stall", stall, 0);
    step();
    chk("lu_mem_op_c", op_c, 55);
    chk("lu_valid", ex_valid, 1);
    chk("lu_ctrl", ex_ctrl, 16'h1234);
    chk("lu_count_hold", stall_count, 1);

    // use_c=0: no stall, load in EX not forwarded
    clear_stages(); ex_load = 1; ex_rd = 7; ex_le = 1; use_c = 0;
    #1 chk("nouse_stall", stall, 0);
    step();
    chk("nouse_valid", ex_valid, 1);
    chk("nouse_op_c", op_c, 11);
    chk("nouse_count", stall_count, 1);

    // id_valid=0 suppresses the hazard
    use_c = 1; id_valid = 0;
    #1 chk("invalid_stall", stall, 0);
    id_valid = 1;

    // Flush beats stall
    flush = 1;
    #1 chk("flush_stall", stall, 0);
    step();
    chk("flush_valid", ex_valid, 0);
    chk("flush_op_c", op_c, 0);
    chk("flush_count", stall_count, 1);
    flush = 0;

    // Saturation near the top
    force dut.stall_count_reg = 32'hFFFF_FFFE;
    #1 release dut.stall_count_reg;
    #1 chk("sat_preload", stall_count, 32'hFFFF_FFFE);
    chk("sat_stall", stall, 1);
    step();
    chk("sat_reach", stall_count, 32'hFFFF_FFFF);
    step();
    chk("sat_hold", stall_count, 32'hFFFF_FFFF);

    // Async reset during a stall discards count
    rst_n = 0;
    #1 chk("arst_count", stall_count, 0);
    chk("arst_valid", ex_valid, 0);
    chk("arst_op_a", op_a, 0);
    step();
    rst_n = 1;
    clear_stages(); ra = 3; pa = 20; use_c = 0; id_ctrl = 16'h00FF;
    step();
    chk("post_rst_op_a", op_a, 20);
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_count", stall_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
